// File: rtl/manchester_receiver.sv
`timescale 1ns/1ps
// Manchester line receiver: oversampled cell decode, LSB-first byte assembly, EOF and coding-error detection.
// Optional feature macro MANRX_RESYNC_EN: realign the phase counter on mid-cell line transitions.
module manchester_receiver #(
    parameter int CLKFREQ = 100_000_000,
    parameter int BAUD    = 9600,
    parameter int SAMPLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       cardet,
    output logic       error,
    output logic       eof
);

    localparam int DIV_RAW = CLKFREQ / (BAUD * SAMPLES);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW      = $clog2(SAMPLES);
    localparam int CW      = $clog2(2 * SAMPLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [PW-1:0] PH_H1     = PW'(SAMPLES / 4);
    localparam logic [PW-1:0] PH_H2     = PW'((3 * SAMPLES) / 4);
    localparam logic [PW-1:0] PH_LAST   = PW'(SAMPLES - 1);
    // The all-high cell that led into EOFCHK already covers one bit time of the two.
    localparam logic [CW-1:0] EOF_LAST  = CW'(SAMPLES - 2);
    localparam logic [CW-1:0] HUNT_LAST = CW'(2 * SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, EOFCHK, HUNT} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          h1_q, h1_d;
    logic          h2_q, h2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          cardet_q, cardet_d;
    logic          error_q, error_d;
    logic          eof_q, eof_d;
    logic          tick;
    logic          rx_fall;

`ifdef MANRX_RESYNC_EN
    localparam logic [PW-1:0] PH_MID    = PW'(SAMPLES / 2);
    localparam logic [PW-1:0] PH_WIN_LO = PW'(SAMPLES / 2 - 2);
    localparam logic [PW-1:0] PH_WIN_HI = PW'(SAMPLES / 2 + 2);

    logic resync_q, resync_d;
    logic rx_edge;
    logic in_window;

    assign rx_edge   = sync2_q ^ prev_q;
    assign in_window = (phase_q >= PH_WIN_LO) && (phase_q <= PH_WIN_HI);
`endif

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign rx_fall = prev_q & ~sync2_q;

    always_comb begin
        sync1_d    = rxd;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        state_d    = state_q;
        phase_d    = phase_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        h1_d       = h1_q;
        h2_d       = h2_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        cardet_d   = cardet_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        eof_d      = 1'b0;
`ifdef MANRX_RESYNC_EN
        resync_d   = (state_q == RECV) ? resync_q : 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d    = RECV;
                    phase_d    = '0;
                    bit_idx_d  = '0;
                    cardet_d   = 1'b1;
                    tick_cnt_d = '0;
                end
            end

            RECV: begin
`ifdef MANRX_RESYNC_EN
                if (rx_edge && in_window) resync_d = 1'b1;
`endif
                if (tick) begin
                    if (phase_q == PH_H1) h1_d = sync2_q;
                    if (phase_q == PH_H2) h2_d = sync2_q;
                    phase_d = phase_q + PW'(1);
`ifdef MANRX_RESYNC_EN
                    if (resync_q || (rx_edge && in_window)) begin
                        phase_d  = PH_MID;
                        resync_d = 1'b0;
                    end
`endif
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (h1_q != h2_q) begin
                            shift_d = {h2_q, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                data_d    = {h2_q, shift_q[7:1]};
                                valid_d   = 1'b1;
                                bit_idx_d = '0;
                            end else begin
                                bit_idx_d = bit_idx_q + 3'd1;
                            end
                        end else if (h1_q && (bit_idx_q == 3'd0)) begin
                            state_d = EOFCHK;
                            cnt_d   = '0;
                        end else begin
                            error_d  = 1'b1;
                            cardet_d = 1'b0;
                            state_d  = HUNT;
                            cnt_d    = '0;
                        end
                    end
                end
            end

            EOFCHK: begin
                // A low line here is the leading half of another cell, not an EOF.
                if (!sync2_q) begin
                    state_d    = RECV;
                    phase_d    = '0;
                    bit_idx_d  = '0;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == EOF_LAST) begin
                        eof_d    = 1'b1;
                        cardet_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            HUNT: begin
                if (tick) begin
                    if (!sync2_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == HUNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            h1_q       <= 1'b0;
            h2_q       <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            cardet_q   <= 1'b0;
            error_q    <= 1'b0;
            eof_q      <= 1'b0;
`ifdef MANRX_RESYNC_EN
            resync_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            h1_q       <= h1_d;
            h2_q       <= h2_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            cardet_q   <= cardet_d;
            error_q    <= error_d;
            eof_q      <= eof_d;
`ifdef MANRX_RESYNC_EN
            resync_q   <= resync_d;
`endif
        end
    end

    assign data   = data_q;
    assign valid  = valid_q;
    assign cardet = cardet_q;
    assign error  = error_q;
    assign eof    = eof_q;

endmodule

// File: tb/tb_manchester_receiver.sv
`timescale 1ns/1ps
// Scoreboard bench for manchester_receiver: a bit-level line model drives frames and pushes the
// byte/EOF/error events it expects; a negedge monitor pops and compares them as the receiver reports.
module tb_manchester_receiver;

    localparam int CLKFREQ      = 614_400;
    localparam int BAUD         = 9600;
    localparam int SAMPLES      = 16;
    localparam int CLK_NS       = 10;
    localparam int HALF_NS      = 320;
    localparam int FAST_HALF_NS = 312;

    localparam logic [3:0] KIND_NONE  = 4'd0;
    localparam logic [3:0] KIND_VALID = 4'd1;
    localparam logic [3:0] KIND_EOF   = 4'd2;
    localparam logic [3:0] KIND_ERR   = 4'd3;

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] value;
    } expEvent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       cardet;
    logic       error;
    logic       eof;

    expEvent_t  expQ[$];
    logic [7:0] obsBytes[$];
    int         total = 0;
    int         bad = 0;
    bit         scoreOn = 1'b1;
    int         errSeen = 0;
    time        lastEofTime = 0;

    manchester_receiver #(
        .CLKFREQ(CLKFREQ),
        .BAUD(BAUD),
        .SAMPLES(SAMPLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .data(data),
        .valid(valid),
        .cardet(cardet),
        .error(error),
        .eof(eof)
    );

    always #(CLK_NS / 2) clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every reported event is matched against the head of the expected-event queue.
    always @(negedge clk) begin : monitor
        logic [3:0] kind;
        expEvent_t  e;
        if (rst) begin
            if ((int'(valid) + int'(eof) + int'(error)) > 1)
                checkOutput("exclusive_pulses", int'(valid) + int'(eof) + int'(error), 1);
            if (valid || eof || error) begin
                kind = valid ? KIND_VALID : (eof ? KIND_EOF : KIND_ERR);
                if (eof) lastEofTime = $time;
                if (scoreOn) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_event", kind, KIND_NONE);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("event_kind", kind, e.kind);
                        if (kind == KIND_VALID) checkOutput("valid_data", data, e.value);
                    end
                end else begin
                    if (valid) obsBytes.push_back(data);
                    if (error) errSeen++;
                end
            end
        end
    end

    task automatic driveCell(input logic b, input int halfNs);
        rxd = ~b;
        #(halfNs);
        rxd = b;
        #(halfNs);
    endtask

    task automatic applyStimulus(input logic [7:0] value, input int halfNs, input bit expectIt);
        if (expectIt) expQ.push_back('{kind: KIND_VALID, value: value});
        for (int i = 0; i < 8; i++) driveCell(value[i], halfNs);
    endtask

    task automatic driveEof(input int halfNs, input bit expectIt);
        if (expectIt) expQ.push_back('{kind: KIND_EOF, value: 8'h00});
        rxd = 1'b1;
        #(4 * halfNs);
    endtask

    task automatic idleCells(input int n);
        rxd = 1'b1;
        #(n * 2 * HALF_NS);
    endtask

    task automatic waitDrain(input string tag);
        int budget = 0;
        while (expQ.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput(tag, expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin : stimulus
        time tEnd;
        int  delayClks;
        bit  driftSeen;
        logic [7:0] wantFast [3];

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_cardet", cardet, 1'b0);
        checkOutput("reset_error", error, 1'b0);
        checkOutput("reset_eof", eof, 1'b0);
        rst = 1'b1;
        idleCells(3);

        // Nominal frame 55, A3, EOF
        applyStimulus(8'h55, HALF_NS, 1'b1);
        checkOutput("s1_cardet_mid", cardet, 1'b1);
        applyStimulus(8'hA3, HALF_NS, 1'b1);
        driveEof(HALF_NS, 1'b1);
        idleCells(2);
        waitDrain("s1_drain");
        checkOutput("s1_cardet_after", cardet, 1'b0);

        // Full low cell at bit 2 of the second byte, then recovery
        applyStimulus(8'h55, HALF_NS, 1'b1);
        expQ.push_back('{kind: KIND_ERR, value: 8'h00});
        driveCell(1'b1, HALF_NS);
        driveCell(1'b1, HALF_NS);
        rxd = 1'b0;
        #(2 * HALF_NS);
        rxd = 1'b1;
        #(HALF_NS);
        checkOutput("s2_cardet_err", cardet, 1'b0);
        #(5 * HALF_NS);
        applyStimulus(8'h55, HALF_NS, 1'b1);
        driveEof(HALF_NS, 1'b1);
        idleCells(2);
        waitDrain("s2_drain");

        // Reset during the fifth bit of a byte
        for (int i = 0; i < 4; i++) driveCell(i[0] ? 1'b0 : 1'b1, HALF_NS);
        rxd = 1'b0;
        #(HALF_NS);
        checkOutput("s3_cardet_before_rst", cardet, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("s3_rst_data", data, 8'h00);
        checkOutput("s3_rst_cardet", cardet, 1'b0);
        checkOutput("s3_rst_valid", valid, 1'b0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idleCells(2);
        applyStimulus(8'h55, HALF_NS, 1'b1);
        applyStimulus(8'h0F, HALF_NS, 1'b1);
        driveEof(HALF_NS, 1'b1);
        idleCells(2);
        waitDrain("s3_drain");

        // Transmitter 2.5% fast
`ifdef MANRX_RESYNC_EN
        applyStimulus(8'h55, FAST_HALF_NS, 1'b1);
        applyStimulus(8'hFF, FAST_HALF_NS, 1'b1);
        applyStimulus(8'h00, FAST_HALF_NS, 1'b1);
        driveEof(FAST_HALF_NS, 1'b1);
        @(negedge clk);
        idleCells(3);
        waitDrain("s4_fast_resync");
`else
        scoreOn = 1'b0;
        errSeen = 0;
        obsBytes.delete();
        applyStimulus(8'h55, FAST_HALF_NS, 1'b0);
        applyStimulus(8'hFF, FAST_HALF_NS, 1'b0);
        applyStimulus(8'h00, FAST_HALF_NS, 1'b0);
        driveEof(FAST_HALF_NS, 1'b0);
        @(negedge clk);
        idleCells(3);
        scoreOn = 1'b1;
        wantFast = '{8'h55, 8'hFF, 8'h00};
        driftSeen = (errSeen > 0) || (obsBytes.size() != 3);
        if (!driftSeen) begin
            for (int i = 0; i < 3; i++)
                if (obsBytes[i] != wantFast[i]) driftSeen = 1'b1;
        end
        checkOutput("s4_drift_detected", driftSeen, 1'b1);
`endif

        // One-tick glitch on an idle line
        idleCells(10);
        expQ.push_back('{kind: KIND_EOF, value: 8'h00});
        rxd = 1'b0;
        #(4 * CLK_NS);
        rxd = 1'b1;
        #(HALF_NS);
        checkOutput("s5_cardet_glitch", cardet, 1'b1);
        #(HALF_NS);
        idleCells(9);
        waitDrain("s5_drain");
        checkOutput("s5_cardet_after", cardet, 1'b0);

        // Back-to-back bytes after the preamble
        lastEofTime = 0;
        applyStimulus(8'h55, HALF_NS, 1'b1);
        applyStimulus(8'hAA, HALF_NS, 1'b1);
        applyStimulus(8'h01, HALF_NS, 1'b1);
        tEnd = $time;
        driveEof(HALF_NS, 1'b1);
        idleCells(2);
        waitDrain("s6_drain");
        delayClks = int'((lastEofTime - tEnd) / CLK_NS);
        checkOutput($sformatf("s6_eof_delay_clks=%0d", delayClks),
                    (delayClks >= 120) && (delayClks <= 136), 1'b1);
        checkOutput("s6_cardet_after", cardet, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
